// File: rtl/mem_access_ctrl_pkg.sv
// Opcode constants and access-size helpers shared by the memory access controller.
// Opcode values follow the MIPS instr[31:26] encoding for the eight load/store ops.
package mem_access_ctrl_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_NONE = 2'd3
    } acc_size_e;

    typedef struct packed {
        logic      valid;
        logic      store;
        logic      sext;
        acc_size_e size;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [5:0] op);
        op_info_t info;
        info = '{valid: 1'b0, store: 1'b0, sext: 1'b0, size: SZ_NONE};
        case (op)
            OP_LB:   info = '{valid: 1'b1, store: 1'b0, sext: 1'b1, size: SZ_BYTE};
            OP_LH:   info = '{valid: 1'b1, store: 1'b0, sext: 1'b1, size: SZ_HALF};
            OP_LW:   info = '{valid: 1'b1, store: 1'b0, sext: 1'b0, size: SZ_WORD};
            OP_LBU:  info = '{valid: 1'b1, store: 1'b0, sext: 1'b0, size: SZ_BYTE};
            OP_LHU:  info = '{valid: 1'b1, store: 1'b0, sext: 1'b0, size: SZ_HALF};
            OP_SB:   info = '{valid: 1'b1, store: 1'b1, sext: 1'b0, size: SZ_BYTE};
            OP_SH:   info = '{valid: 1'b1, store: 1'b1, sext: 1'b0, size: SZ_HALF};
            OP_SW:   info = '{valid: 1'b1, store: 1'b1, sext: 1'b0, size: SZ_WORD};
            default: info = '{valid: 1'b0, store: 1'b0, sext: 1'b0, size: SZ_NONE};
        endcase
        return info;
    endfunction

    function automatic logic op_accepted(input logic [5:0] op);
        op_info_t info;
        info = decode_op(op);
        return info.valid;
    endfunction

    function automatic acc_size_e op_size(input logic [5:0] op);
        op_info_t info;
        info = decode_op(op);
        return info.size;
    endfunction

    function automatic logic is_misaligned(input acc_size_e size, input logic [1:0] lo);
        logic mis;
        case (size)
            SZ_HALF: mis = lo[0];
            SZ_WORD: mis = |lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Byte lane selects the low byte of the shifted word; half lane uses addr[1] only.
    function automatic logic [31:0] extract_load(input acc_size_e size, input logic sext,
                                                 input logic [1:0] lo, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {lo, 3'b000});
        h = 16'(word >> {lo[1], 4'b0000});
        case (size)
            SZ_BYTE: r = {{24{sext & b[7]}}, b};
            SZ_HALF: r = {{16{sext & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] replicate_wdata(input acc_size_e size, input logic [31:0] wdata);
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {4{wdata[7:0]}};
            SZ_HALF: r = {2{wdata[15:0]}};
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_be_gen.sv
// Combinational byte-enable generator for the eight load/store opcodes.
// Loads get the same enables as the matching store so memory sees the accessed lanes.
module mem_be_gen
    import mem_access_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] be_o
);

    always_comb begin
        be_o = 4'b0000;
        case (op_i)
            OP_LW, OP_SW:         be_o = 4'b1111;
            OP_LH, OP_LHU, OP_SH: be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            OP_LB, OP_LBU, OP_SB: be_o = 4'b0001 << addr_lo_i;
            default:              be_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the CPU control FSM and a ready-handshake data memory.
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [5:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    // state  | meaning
    // IDLE   | waiting for an accepted load/store request
    // ACCESS | memory request held, waiting for mem_ready or timeout
    // DONE   | one-cycle completion pulse
    // ERR    | one-cycle completion pulse with err, rdata untouched
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [1:0] ST_ERR    = 2'd3;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;

    op_info_t    lat_info;
    logic        in_accept;
    logic        in_trap;
    logic        in_access;
    logic [3:0]  be;

    assign lat_info  = decode_op(op_q);
    assign in_accept = req_i & op_accepted(op_i);
    assign in_access = (state_q == ST_ACCESS);

`ifdef MISALIGN_TRAP_EN
    assign in_trap = is_misaligned(op_size(op_i), addr_i[1:0]);
`else
    assign in_trap = 1'b0;
`endif

    mem_be_gen u_be_gen (
        .op_i      (op_q),
        .addr_lo_i (addr_q[1:0]),
        .be_o      (be)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_accept) begin
                    op_d    = op_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    cnt_d   = 8'd0;
                    state_d = in_trap ? ST_ERR : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // mem_ready takes priority over a timeout landing in the same cycle
                if (mem_ready_i) begin
                    if (!lat_info.store) begin
                        rdata_d = extract_load(lat_info.size, lat_info.sext, addr_q[1:0], mem_rdata_i);
                    end
                    cnt_d   = 8'd0;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= 6'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory-side outputs are forced to zero outside ACCESS so an abandoned access leaves nothing driven.
    assign mem_en_o    = in_access & lat_info.valid;
    assign mem_we_o    = mem_en_o & lat_info.store;
    assign mem_addr_o  = mem_en_o ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_be_o    = mem_en_o ? be : 4'b0000;
    assign mem_wdata_o = mem_we_o ? replicate_wdata(lat_info.size, wdata_q) : 32'd0;

    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = (state_q == ST_DONE) | (state_q == ST_ERR);
    assign err_o   = (state_q == ST_ERR);
    assign rdata_o = rdata_q;

endmodule
